// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph constants and digit count shared by the seven-segment scan driver.
package seg7_pkg;
    localparam int NUM_DIGITS = 4;
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational nibble to active-high {g..a} glyph; non-decimal nibbles show a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);
    always_comb begin
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/bcd_seg7_scan.sv
// bcd_seg7_scan: 4-digit common-anode scan driver with per-frame snapshot, leading-zero
// blanking, dead-time and 8-level brightness PWM; all outputs registered.
module bcd_seg7_scan
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV   = 250,
    parameter int DEAD_CYCLES   = 4,
    parameter int BLANK_LEADING = 1
) (
    input  logic        i_clk_1mhz,
    input  logic        i_reset,
    input  logic [15:0] i_bcd_data,
    input  logic [3:0]  i_dp_mask,
    input  logic [2:0]  i_brightness,
    output logic [3:0]  o_anode_n,
    output logic [6:0]  o_seg_n,
    output logic        o_dp_n,
    output logic        o_frame_done
);
    localparam int DW = $clog2(REFRESH_DIV);

    logic [DW-1:0] r_div;
    logic [1:0]    r_digit;
    logic [2:0]    r_pwm;
    logic [15:0]   r_bcd;
    logic [3:0]    r_dp;
    logic [2:0]    r_bright;

    logic          w_last_slot, w_snap, w_blank, w_dp, w_on;
    logic [3:0]    w_nib, w_zero, w_lead;
    logic [6:0]    w_glyph, w_seg;

    assign w_last_slot = r_div == DW'(REFRESH_DIV - 1);
    assign w_snap      = w_last_slot && r_digit == 2'(NUM_DIGITS - 1);
    assign w_nib       = r_bcd[{r_digit, 2'b00} +: 4];

    always_comb begin
        for (int n = 0; n < NUM_DIGITS; n++) w_zero[n] = r_bcd[4*n +: 4] == 4'd0;
    end

    // A digit is a leading zero only if it and every more significant nibble are zero.
    assign w_lead  = {w_zero[3], &w_zero[3:2], &w_zero[3:1], 1'b0};
    assign w_blank = BLANK_LEADING != 0 && w_lead[r_digit];
    assign w_dp    = r_dp[r_digit];
    // A blanked digit without a decimal point keeps its anode off for the whole slot.
    assign w_on    = r_div >= DW'(DEAD_CYCLES) && r_pwm <= r_bright && (!w_blank || w_dp);
    assign w_seg   = w_blank ? SEG_BLANK : w_glyph;

    bcd_to_seg7 u_dec (
        .i_bcd (w_nib),
        .o_seg (w_glyph)
    );

    always_ff @(posedge i_clk_1mhz or posedge i_reset) begin
        if (i_reset) begin
            r_div        <= '0;
            r_digit      <= '0;
            r_pwm        <= '0;
            r_bcd        <= '0;
            r_dp         <= '0;
            r_bright     <= 3'd7;
            o_anode_n    <= 4'hF;
            o_seg_n      <= 7'h7F;
            o_dp_n       <= 1'b1;
            o_frame_done <= 1'b0;
        end else begin
            r_div        <= w_last_slot ? '0 : r_div + DW'(1);
            r_digit      <= w_last_slot ? r_digit + 2'd1 : r_digit;
            r_pwm        <= r_pwm + 3'd1;
            if (w_snap) begin
                r_bcd    <= i_bcd_data;
                r_dp     <= i_dp_mask;
                r_bright <= i_brightness;
            end
            o_anode_n    <= w_on ? ~(4'b0001 << r_digit) : 4'hF;
            o_seg_n      <= w_on ? ~w_seg : 7'h7F;
            o_dp_n       <= ~(w_on && w_dp);
            o_frame_done <= w_snap;
        end
    end
endmodule

// File: tb/tb_bcd_seg7_scan.sv
// tb_bcd_seg7_scan: directed checks of reset, glyphs, blanking, brightness PWM,
// snapshot isolation and mid-scan reset with hand-computed expectations.
`timescale 1ns/1ps
module tb_bcd_seg7_scan;
    localparam logic [6:0] L0 = 7'b1000000;
    localparam logic [6:0] L1 = 7'b1111001;
    localparam logic [6:0] L2 = 7'b0100100;
    localparam logic [6:0] L3 = 7'b0110000;
    localparam logic [6:0] L4 = 7'b0011001;
    localparam logic [6:0] L5 = 7'b0010010;
    localparam logic [6:0] L7 = 7'b1111000;
    localparam logic [6:0] L9 = 7'b0010000;
    localparam logic [6:0] LD = 7'b0111111;
    localparam logic [6:0] LB = 7'h7F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bcd = 16'h1234;
    logic [3:0]  dpm = 4'b0000;
    logic [2:0]  br  = 3'd7;
    logic [3:0]  anode, nb_anode;
    logic [6:0]  seg, nb_seg;
    logic        dp, fd, nb_dp, nb_fd;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    bcd_seg7_scan dut (
        .i_clk_1mhz   (clk),
        .i_reset      (rst),
        .i_bcd_data   (bcd),
        .i_dp_mask    (dpm),
        .i_brightness (br),
        .o_anode_n    (anode),
        .o_seg_n      (seg),
        .o_dp_n       (dp),
        .o_frame_done (fd)
    );

    bcd_seg7_scan #(.BLANK_LEADING(0)) dut_nb (
        .i_clk_1mhz   (clk),
        .i_reset      (rst),
        .i_bcd_data   (bcd),
        .i_dp_mask    (dpm),
        .i_brightness (br),
        .o_anode_n    (nb_anode),
        .o_seg_n      (nb_seg),
        .o_dp_n       (nb_dp),
        .o_frame_done (nb_fd)
    );

    always #5 clk = ~clk;

    // cyc = clock edges since reset release; outputs after edge c reflect counter state c-1.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic probe(input string tag, input int c, input logic [3:0] e_an,
                         input logic [6:0] e_seg, input logic e_dp);
        at(c);
        check({tag, ".anode"}, anode, e_an);
        check({tag, ".seg"}, seg, e_seg);
        check({tag, ".dp"}, dp, e_dp);
    endtask

    int on_cnt [4];
    int dead_err, multi_err, off_err;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst.anode", anode, 4'hF);
        check("rst.seg", seg, LB);
        check("rst.dp", dp, 1'b1);
        check("rst.fd", fd, 1'b0);
        @(negedge clk) rst = 1'b0;

        // Frame 1 shows reset shadow "   0"; 1234 is captured at its end.
        probe("t1_d0", 101, 4'b1110, L0, 1'b1);
        probe("t1_d1", 301, 4'hF, LB, 1'b1);
        probe("t1_d3", 851, 4'hF, LB, 1'b1);
        at(999);  check("t1_fd_pre", fd, 1'b0);
        at(1000); check("t1_fd", fd, 1'b1);
        at(1001); check("t1_fd_post", fd, 1'b0);
        at(1004); check("t1_dead", anode, 4'hF);
        probe("t1_f2d0", 1005, 4'b1110, L4, 1'b1);
        probe("t1_f2d1", 1351, 4'b1101, L3, 1'b1);
        probe("t1_f2d2", 1601, 4'b1011, L2, 1'b1);
        probe("t1_f2d3", 1851, 4'b0111, L1, 1'b1);

        at(1900);
        bcd = 16'h0050;
        dpm = 4'b0100;
        at(2000); check("t2_fd", fd, 1'b1);
        probe("t2_d0", 2101, 4'b1110, L0, 1'b1);
        probe("t2_d1", 2351, 4'b1101, L5, 1'b1);
        probe("t2_d2", 2601, 4'b1011, LB, 1'b0);
        check("t2_nb_d2.anode", nb_anode, 4'b1011);
        check("t2_nb_d2.seg", nb_seg, L0);
        check("t2_nb_d2.dp", nb_dp, 1'b0);
        off_err = 0;
        for (int c = 2751; c <= 3000; c++) begin
            at(c);
            if (anode !== 4'hF || seg !== LB) off_err++;
            if (c == 2851) begin
                check("t2_nb_d3.anode", nb_anode, 4'b0111);
                check("t2_nb_d3.seg", nb_seg, L0);
            end
            if (c == 2900) begin
                bcd = 16'h0A07;
                dpm = 4'b0000;
            end
        end
        check("t2_d3_dark_cycles", 16'(off_err), 16'd0);

        probe("t3_d0", 3101, 4'b1110, L7, 1'b1);
        probe("t3_d1", 3351, 4'b1101, L0, 1'b1);
        probe("t3_d2", 3601, 4'b1011, LD, 1'b1);
        probe("t3_d3", 3851, 4'hF, LB, 1'b1);

        at(3900);
        br  = 3'd3;
        bcd = 16'h1234;
        at(4000); check("t4_fd", fd, 1'b1);
        // PWM phase shifts by 2 each 250-cycle slot, so per-digit on-time is 122/124/124/122 (mean 123).
        on_cnt = '{0, 0, 0, 0};
        dead_err = 0;
        multi_err = 0;
        for (int c = 4001; c <= 5000; c++) begin
            at(c);
            for (int k = 0; k < 4; k++) on_cnt[k] += int'(!anode[k]);
            if ((c - 1) % 250 < 4 && anode !== 4'hF) dead_err++;
            if (!$onehot0(~anode)) multi_err++;
        end
        check("t4_on_d0", 16'(on_cnt[0]), 16'd122);
        check("t4_on_d1", 16'(on_cnt[1]), 16'd124);
        check("t4_on_d2", 16'(on_cnt[2]), 16'd124);
        check("t4_on_d3", 16'(on_cnt[3]), 16'd122);
        check("t4_dead", 16'(dead_err), 16'd0);
        check("t4_multi", 16'(multi_err), 16'd0);

        br  = 3'd7;
        bcd = 16'h1111;
        probe("t5_d0", 6101, 4'b1110, L1, 1'b1);
        at(6500);
        bcd = 16'h9999;
        probe("t5_d2", 6601, 4'b1011, L1, 1'b1);
        probe("t5_d3", 6851, 4'b0111, L1, 1'b1);
        at(7000); check("t5_fd", fd, 1'b1);
        probe("t5_new_d0", 7101, 4'b1110, L9, 1'b1);
        probe("t5_new_d1", 7351, 4'b1101, L9, 1'b1);

        probe("t6_pre", 7601, 4'b1011, L9, 1'b1);
        #3 rst = 1'b1;
        #1;
        check("t6_async.anode", anode, 4'hF);
        check("t6_async.seg", seg, LB);
        check("t6_async.dp", dp, 1'b1);
        check("t6_async.fd", fd, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        at(4); check("t6_dead", anode, 4'hF);
        probe("t6_d0", 5, 4'b1110, L0, 1'b1);
        probe("t6_d1", 301, 4'hF, LB, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
